// File: rtl/instr_compress_packer_pkg.sv
// Shared decode constants for the RV32 -> RVC compressor and parcel packer.
package instr_compress_packer_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 16;

  // RV32 base opcodes
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // RVC quadrants and major functs
  localparam logic [1:0] CQ0 = 2'b00;
  localparam logic [1:0] CQ1 = 2'b01;
  localparam logic [1:0] CQ2 = 2'b10;

  localparam logic [2:0] CF3_ADDI = 3'b000;
  localparam logic [2:0] CF3_LI   = 3'b010;
  localparam logic [2:0] CF3_SLLI = 3'b000;
  localparam logic [2:0] CF3_LW   = 3'b010;
  localparam logic [2:0] CF3_SW   = 3'b110;
  localparam logic [2:0] CF3_LWSP = 3'b010;
  localparam logic [2:0] CF3_SWSP = 3'b110;
  localparam logic [3:0] CF4_MV   = 4'b1000;
  localparam logic [3:0] CF4_ADD  = 4'b1001;
  localparam logic [5:0] CF6_ARITH = 6'b100011;

  localparam logic [PW-1:0] C_NOP = 16'h0001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32_r_t;

  // Register reachable by the 3-bit RVC register fields (x8..x15)
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/instr_compress_packer_compressor.sv
// Combinational RV32 -> RVC rewriter; only non-control-flow forms are matched.
module instr_compressor
  import instr_compress_packer_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output logic            o_is_comp,
  output logic [PW-1:0]   o_cinstr
);

  rv32_r_t     f;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        imm6_ok;
  logic        cregs_ok;
  logic [1:0]  arith_f2;
  logic        arith_ok;

  assign f        = rv32_r_t'(i_instr);
  assign imm_i    = i_instr[31:20];
  assign imm_s    = {i_instr[31:25], i_instr[11:7]};
  assign imm6_ok  = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
  assign cregs_ok = is_creg(f.rd) && is_creg(f.rs1) && is_creg(f.rs2);

  // Map base funct3/funct7 to the C.SUB/XOR/OR/AND funct2 field
  always_comb begin
    arith_f2 = 2'b00;
    arith_ok = 1'b0;
    if (f.funct3 == F3_ADD_SUB && f.funct7 == F7_SUB) begin
      arith_f2 = 2'b00;
      arith_ok = 1'b1;
    end else if (f.funct7 == F7_BASE) begin
      case (f.funct3)
        F3_XOR:  begin arith_f2 = 2'b01; arith_ok = 1'b1; end
        F3_OR:   begin arith_f2 = 2'b10; arith_ok = 1'b1; end
        F3_AND:  begin arith_f2 = 2'b11; arith_ok = 1'b1; end
        default: begin arith_f2 = 2'b00; arith_ok = 1'b0; end
      endcase
    end
  end

  always_comb begin
    o_is_comp = 1'b0;
    o_cinstr  = 16'h0000;
    if (i_instr[1:0] == 2'b11) begin
      case (f.opcode)
        OP_IMM: begin
          if (f.funct3 == F3_ADD_SUB) begin
            if (f.rd == 5'd0 && f.rs1 == 5'd0 && imm_i == 12'd0) begin
              o_is_comp = 1'b1;
              o_cinstr  = C_NOP;
            end else if (f.rd != 5'd0 && f.rs1 == f.rd && imm_i != 12'd0 && imm6_ok) begin
              o_is_comp = 1'b1;
              o_cinstr  = {CF3_ADDI, imm_i[5], f.rd, imm_i[4:0], CQ1};
            end else if (f.rd != 5'd0 && f.rs1 == 5'd0 && imm6_ok) begin
              o_is_comp = 1'b1;
              o_cinstr  = {CF3_LI, imm_i[5], f.rd, imm_i[4:0], CQ1};
            end
          end else if (f.funct3 == F3_SLL && f.funct7 == F7_BASE && f.rd != 5'd0
                       && f.rs1 == f.rd && f.rs2 != 5'd0) begin
            o_is_comp = 1'b1;
            o_cinstr  = {CF3_SLLI, 1'b0, f.rd, f.rs2, CQ2};
          end
        end
        OP: begin
          if (f.funct3 == F3_ADD_SUB && f.funct7 == F7_BASE && f.rd != 5'd0
              && f.rs2 != 5'd0 && f.rs1 == 5'd0) begin
            o_is_comp = 1'b1;
            o_cinstr  = {CF4_MV, f.rd, f.rs2, CQ2};
          end else if (f.funct3 == F3_ADD_SUB && f.funct7 == F7_BASE && f.rd != 5'd0
                       && f.rs2 != 5'd0 && f.rs1 == f.rd) begin
            o_is_comp = 1'b1;
            o_cinstr  = {CF4_ADD, f.rd, f.rs2, CQ2};
          end else if (arith_ok && cregs_ok && f.rs1 == f.rd) begin
            o_is_comp = 1'b1;
            o_cinstr  = {CF6_ARITH, f.rd[2:0], arith_f2, f.rs2[2:0], CQ1};
          end
        end
        LOAD: begin
          if (f.funct3 == F3_WORD) begin
            if (is_creg(f.rd) && is_creg(f.rs1) && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
              o_is_comp = 1'b1;
              o_cinstr  = {CF3_LW, imm_i[5:3], f.rs1[2:0], imm_i[2], imm_i[6], f.rd[2:0], CQ0};
            end else if (f.rs1 == 5'd2 && f.rd != 5'd0 && imm_i[11:8] == 4'd0
                         && imm_i[1:0] == 2'd0) begin
              o_is_comp = 1'b1;
              o_cinstr  = {CF3_LWSP, imm_i[5], f.rd, imm_i[4:2], imm_i[7:6], CQ2};
            end
          end
        end
        STORE: begin
          if (f.funct3 == F3_WORD) begin
            if (is_creg(f.rs2) && is_creg(f.rs1) && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
              o_is_comp = 1'b1;
              o_cinstr  = {CF3_SW, imm_s[5:3], f.rs1[2:0], imm_s[2], imm_s[6], f.rs2[2:0], CQ0};
            end else if (f.rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0) begin
              o_is_comp = 1'b1;
              o_cinstr  = {CF3_SWSP, imm_s[5:2], imm_s[7:6], f.rs2, CQ2};
            end
          end
        end
        default: begin
          o_is_comp = 1'b0;
          o_cinstr  = 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_compress_packer.sv
// Streaming RV32 compressor + little-endian 16/32-bit parcel packer.
// Optional counters enabled by INSTR_PACK_STATS_EN.
module instr_compress_packer
  import instr_compress_packer_pkg::*;
#(
  parameter logic [15:0] PAD_PARCEL = C_NOP
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic            i_flush,
  output logic            o_flush_done,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_word
`ifdef INSTR_PACK_STATS_EN
  ,
  output logic [31:0]     o_cnt_in,
  output logic [31:0]     o_cnt_comp,
  output logic [31:0]     o_cnt_out
`endif
);

  state_e          state_q, state_d;
  logic [PW-1:0]   hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic            out_vld_q, out_vld_d;
  logic [XLEN-1:0] word_q, word_d;
  logic            done_q, done_d;

  logic            is_comp;
  logic [PW-1:0]   cinstr;
  logic            in_is16;
  logic            p_is16;
  logic [PW-1:0]   parcel16;
  logic            slot_free;
  logic            in_ready;
  logic            accept;

  instr_compressor u_comp (
    .i_instr   (i_instr),
    .o_is_comp (is_comp),
    .o_cinstr  (cinstr)
  );

  assign in_is16   = (i_instr[1:0] != 2'b11);
  assign p_is16    = in_is16 | is_comp;
  assign parcel16  = in_is16 ? i_instr[15:0] : cinstr;
  assign slot_free = !out_vld_q || i_out_ready;
  // Held low through reset so nothing is taken while state is being cleared
  assign in_ready  = !i_rst && (state_q == ST_RUN) && slot_free && !i_flush;
  assign accept    = i_in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_vld_d  = out_vld_q && !i_out_ready;
    word_d     = word_q;
    done_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_flush) begin
          state_d = ST_FLUSH;
        end else if (accept) begin
          if (p_is16) begin
            if (hold_vld_q) begin
              word_d     = {parcel16, hold_q};
              out_vld_d  = 1'b1;
              hold_vld_d = 1'b0;
            end else begin
              hold_d     = parcel16;
              hold_vld_d = 1'b1;
            end
          end else if (hold_vld_q) begin
            // Straddling word: low half completes this word, high half is carried
            word_d    = {i_instr[15:0], hold_q};
            out_vld_d = 1'b1;
            hold_d    = i_instr[31:16];
          end else begin
            word_d    = i_instr;
            out_vld_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (!hold_vld_q) begin
          state_d = ST_DRAIN;
        end else if (slot_free) begin
          word_d     = {PAD_PARCEL, hold_q};
          out_vld_d  = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (slot_free) begin
          done_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      word_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      out_vld_q  <= out_vld_d;
      word_q     <= word_d;
      done_q     <= done_d;
    end
  end

  assign o_in_ready   = in_ready;
  assign o_out_valid  = out_vld_q;
  assign o_word       = word_q;
  assign o_flush_done = done_q;

`ifdef INSTR_PACK_STATS_EN
  logic [31:0] cnt_in_q, cnt_comp_q, cnt_out_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_in_q   <= '0;
      cnt_comp_q <= '0;
      cnt_out_q  <= '0;
    end else begin
      if (accept) begin
        cnt_in_q <= cnt_in_q + 32'd1;
      end
      if (accept && is_comp) begin
        cnt_comp_q <= cnt_comp_q + 32'd1;
      end
      if (out_vld_q && i_out_ready) begin
        cnt_out_q <= cnt_out_q + 32'd1;
      end
    end
  end

  assign o_cnt_in   = cnt_in_q;
  assign o_cnt_comp = cnt_comp_q;
  assign o_cnt_out  = cnt_out_q;
`endif

endmodule
